// File: rtl/div_wb_scheduler.sv
// div_wb_scheduler: tracks in-flight ops of the pipelined divider, publishes
// per-slot busy info for decode hazards, arbitrates the RF write port and
// drains outstanding divides before acknowledging a halt.
// Optional: define DIV_WB_PERF_EN to add perf_collide_cnt / perf_raw_cnt.
module div_wb_scheduler #(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned COLLIDE_SLOT = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_rd,
   input  logic                 issue_get_rem,
   input  logic                 flush,
   input  logic                 dec_reg_we,
   input  logic                 dec_is_div,
   input  logic [4:0]           dec_rs1,
   input  logic [4:0]           dec_rs2,
   input  logic                 alu_wb_valid,
   input  logic [4:0]           alu_wb_rd,
   input  logic                 halt_req,
   output logic [7*DEPTH-1:0]   busy_flat,
   output logic                 div_wb_valid,
   output logic [4:0]           div_wb_rd,
   output logic                 wb_sel_div,
   output logic                 alu_wb_drop,
   output logic                 raw_conflict,
   output logic                 collide_stall,
   output logic [4:0]           inflight,
   output logic                 halt_ack
`ifdef DIV_WB_PERF_EN
   ,
   output logic [31:0]          perf_collide_cnt,
   output logic [31:0]          perf_raw_cnt
`endif
);

   typedef struct packed {
      logic       valid;
      logic       get_rem;
      logic [4:0] rd;
   } slot_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   slot_t [DEPTH-1:0] slot_q, slot_d;
   logic [4:0]        inflight_q, inflight_d;
   state_t            state_q, state_d;
   logic              halt_ack_q, halt_ack_d;
   logic              enter_c;
   logic              raw_c;

   // New entry: rd=x0 and flushed issues never occupy a slot; payload zeroed when invalid
   always_comb begin
      enter_c    = issue_valid & ~flush & (issue_rd != 5'd0);
      slot_d     = {slot_q[DEPTH-2:0], slot_t'('0)};
      if (enter_c) begin
         slot_d[0].valid   = 1'b1;
         slot_d[0].get_rem = issue_get_rem;
         slot_d[0].rd      = issue_rd;
      end
      inflight_d = inflight_q + 5'(enter_c) - 5'(slot_q[DEPTH-1].valid);
   end

   // Halt-drain sequencing; halt_ack rises together with entry into HALT
   always_comb begin
      state_d    = state_q;
      halt_ack_d = halt_ack_q;
      unique case (state_q)
         ST_RUN: begin
            if (halt_req) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((inflight_q == 5'd0) && !enter_c) begin
               state_d    = ST_HALT;
               halt_ack_d = 1'b1;
            end
         end
         ST_HALT: begin
            halt_ack_d = 1'b1;
         end
         default: begin
            state_d    = ST_RUN;
            halt_ack_d = 1'b0;
         end
      endcase
   end

   // Slot pipeline, occupancy counter and FSM registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_q     <= '0;
         inflight_q <= 5'd0;
         state_q    <= ST_RUN;
         halt_ack_q <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         inflight_q <= inflight_d;
         state_q    <= state_d;
         halt_ack_q <= halt_ack_d;
      end
   end

   // RAW hazard: any valid slot whose rd matches a non-zero decode source
   always_comb begin
      raw_c = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (slot_q[k].valid &&
             (((dec_rs1 != 5'd0) && (slot_q[k].rd == dec_rs1)) ||
              ((dec_rs2 != 5'd0) && (slot_q[k].rd == dec_rs2)))) begin
            raw_c = 1'b1;
         end
      end
   end

   // Output mapping; divider always owns the write port when retiring
   always_comb begin
      busy_flat     = slot_q;
      div_wb_valid  = slot_q[DEPTH-1].valid;
      div_wb_rd     = slot_q[DEPTH-1].rd;
      wb_sel_div    = slot_q[DEPTH-1].valid;
      alu_wb_drop   = slot_q[DEPTH-1].valid & alu_wb_valid;
      raw_conflict  = raw_c;
      collide_stall = slot_q[COLLIDE_SLOT].valid & dec_reg_we & ~dec_is_div;
      inflight      = inflight_q;
      halt_ack      = halt_ack_q;
   end

`ifdef DIV_WB_PERF_EN
   logic [31:0] perf_collide_q, perf_collide_d;
   logic [31:0] perf_raw_q, perf_raw_d;

   // Saturating event counters
   always_comb begin
      perf_collide_d = perf_collide_q;
      perf_raw_d     = perf_raw_q;
      if (collide_stall && (perf_collide_q != 32'hFFFF_FFFF))
         perf_collide_d = perf_collide_q + 32'd1;
      if (raw_c && !collide_stall && (perf_raw_q != 32'hFFFF_FFFF))
         perf_raw_d = perf_raw_q + 32'd1;
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_collide_q <= 32'd0;
         perf_raw_q     <= 32'd0;
      end else begin
         perf_collide_q <= perf_collide_d;
         perf_raw_q     <= perf_raw_d;
      end
   end

   assign perf_collide_cnt = perf_collide_q;
   assign perf_raw_cnt     = perf_raw_q;
`endif

endmodule

// File: tb/tb_div_wb_scheduler.sv
// Randomized scoreboard bench for div_wb_scheduler.
module tb_div_wb_scheduler;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CS    = 5;

   logic                clk;
   logic                rst;
   logic                issue_valid;
   logic [4:0]          issue_rd;
   logic                issue_get_rem;
   logic                flush;
   logic                dec_reg_we;
   logic                dec_is_div;
   logic [4:0]          dec_rs1;
   logic [4:0]          dec_rs2;
   logic                alu_wb_valid;
   logic [4:0]          alu_wb_rd;
   logic                halt_req;
   logic [7*DEPTH-1:0]  busy_flat;
   logic                div_wb_valid;
   logic [4:0]          div_wb_rd;
   logic                wb_sel_div;
   logic                alu_wb_drop;
   logic                raw_conflict;
   logic                collide_stall;
   logic [4:0]          inflight;
   logic                halt_ack;
`ifdef DIV_WB_PERF_EN
   logic [31:0]         perf_collide_cnt;
   logic [31:0]         perf_raw_cnt;
`endif

   div_wb_scheduler #(.DEPTH(DEPTH), .COLLIDE_SLOT(CS)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_get_rem(issue_get_rem),
      .flush(flush), .dec_reg_we(dec_reg_we), .dec_is_div(dec_is_div),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .halt_req(halt_req),
      .busy_flat(busy_flat), .div_wb_valid(div_wb_valid), .div_wb_rd(div_wb_rd),
      .wb_sel_div(wb_sel_div), .alu_wb_drop(alu_wb_drop),
      .raw_conflict(raw_conflict), .collide_stall(collide_stall),
      .inflight(inflight), .halt_ack(halt_ack)
`ifdef DIV_WB_PERF_EN
      , .perf_collide_cnt(perf_collide_cnt), .perf_raw_cnt(perf_raw_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: log of accepted issues with the cycle they were presented
   typedef struct { int c; logic gr; logic [4:0] rd; } op_t;
   typedef struct { int due; logic [4:0] rd; } wb_t;
   op_t  log_q[$];
   wb_t  exp_q[$];
   int   n_cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   drain_from = -1;
   int   ack_from = -1;
   longint unsigned m_col = 0;
   longint unsigned m_raw = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, n_cyc, act, exp);
      end
   endtask

   // Monitor: compares every cycle at negedge, then folds this cycle's inputs into the model
   logic [7*DEPTH-1:0] e_busy, e_mask;
   int   e_live, k;
   logic e_raw, e_cs, e_wb, acc;
   wb_t  w;
   always @(negedge clk) begin
      if (!rst) begin
         log_q.delete();
         exp_q.delete();
         drain_from = -1;
         ack_from   = -1;
         m_col      = 0;
         m_raw      = 0;
      end else begin
         while (log_q.size() > 0 && (n_cyc - log_q[0].c - 1) >= int'(DEPTH))
            void'(log_q.pop_front());
         e_busy = '0; e_mask = '0; e_live = 0; e_raw = 1'b0; e_cs = 1'b0;
         for (int j = 0; j < int'(DEPTH); j++) e_mask[7*j+6] = 1'b1;
         foreach (log_q[i]) begin
            k = n_cyc - log_q[i].c - 1;
            if (k >= 0 && k < int'(DEPTH)) begin
               e_busy[7*k +: 7] = {1'b1, log_q[i].gr, log_q[i].rd};
               e_mask[7*k +: 7] = 7'h7F;
               e_live++;
               if ((dec_rs1 != 5'd0 && log_q[i].rd == dec_rs1) ||
                   (dec_rs2 != 5'd0 && log_q[i].rd == dec_rs2)) e_raw = 1'b1;
               if (k == int'(CS)) e_cs = 1'b1;
            end
         end
         e_wb = (exp_q.size() > 0) && (exp_q[0].due == n_cyc);
         check("busy_flat", 64'(busy_flat & e_mask), 64'(e_busy));
         check("inflight", 64'(inflight), 64'(e_live));
         check("raw_conflict", 64'(raw_conflict), 64'(e_raw));
         check("collide_stall", 64'(collide_stall), 64'(e_cs & dec_reg_we & ~dec_is_div));
         check("div_wb_valid", 64'(div_wb_valid), 64'(e_wb));
         check("wb_sel_div", 64'(wb_sel_div), 64'(e_wb));
         check("alu_wb_drop", 64'(alu_wb_drop), 64'(e_wb & alu_wb_valid));
         check("halt_ack", 64'(halt_ack), 64'((ack_from >= 0) && (n_cyc >= ack_from)));
         if (div_wb_valid && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("div_wb_rd", 64'(div_wb_rd), 64'(w.rd));
            check("div_wb_time", 64'(n_cyc), 64'(w.due));
         end
`ifdef DIV_WB_PERF_EN
         check("perf_collide", 64'(perf_collide_cnt), 64'(m_col));
         check("perf_raw", 64'(perf_raw_cnt), 64'(m_raw));
         if (e_cs & dec_reg_we & ~dec_is_div) m_col++;
         else if (e_raw) m_raw++;
`endif
         acc = issue_valid && !flush && (issue_rd != 5'd0);
         if (ack_from < 0 && drain_from >= 0 && drain_from <= n_cyc && e_live == 0 && !acc)
            ack_from = n_cyc + 1;
         if (drain_from < 0 && halt_req) drain_from = n_cyc + 1;
         if (acc) begin
            log_q.push_back('{c: n_cyc, gr: issue_get_rem, rd: issue_rd});
            exp_q.push_back('{due: n_cyc + int'(DEPTH), rd: issue_rd});
         end
      end
      n_cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0; issue_rd = 5'd0; issue_get_rem = 1'b0; flush = 1'b0;
      dec_reg_we = 1'b0; dec_is_div = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
      alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; halt_req = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic gr);
      issue_valid = 1'b1; issue_rd = rd; issue_get_rem = gr;
   endtask

   task automatic rand_cycles(input int n, input bit with_halt);
      for (int i = 0; i < n; i++) begin
         issue_valid   = ($urandom_range(0, 9) < 6);
         issue_rd      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         issue_get_rem = 1'($urandom_range(0, 1));
         flush         = ($urandom_range(0, 6) == 0);
         dec_reg_we    = 1'($urandom_range(0, 1));
         dec_is_div    = ($urandom_range(0, 3) == 0);
         dec_rs1       = 5'($urandom_range(0, 7));
         dec_rs2       = 5'($urandom_range(0, 9));
         alu_wb_valid  = 1'($urandom_range(0, 1));
         alu_wb_rd     = 5'($urandom_range(0, 31));
         halt_req      = with_halt && ($urandom_range(0, 3) == 0);
         tick();
      end
      idle_inputs();
   endtask

   // Asynchronous reset away from any clock edge, checked immediately
   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("rst_busy", 64'(busy_flat), 64'd0);
      check("rst_inflight", 64'(inflight), 64'd0);
      check("rst_div_wb", 64'(div_wb_valid), 64'd0);
      check("rst_halt_ack", 64'(halt_ack), 64'd0);
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d actual=running expected=finished", n_cyc);
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      check("init_busy", 64'(busy_flat), 64'd0);
      check("init_inflight", 64'(inflight), 64'd0);
      check("init_halt_ack", 64'(halt_ack), 64'd0);
      check("init_raw", 64'(raw_conflict), 64'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      tick(); tick();

      // single divide, rd=5, watched by decode rs1
      issue(5'd5, 1'b0); dec_rs1 = 5'd5; tick();
      issue_valid = 1'b0; repeat (11) tick();

      // back-to-back rd=3 saturates the pipeline
      dec_rs1 = 5'd3;
      repeat (10) begin issue(5'd3, 1'b1); tick(); end
      issue_valid = 1'b0; repeat (11) tick();

      // rd=x0 and flushed issue never occupy a slot
      idle_inputs();
      issue(5'd0, 1'b0); tick();
      issue(5'd7, 1'b0); flush = 1'b1; tick();
      idle_inputs(); repeat (10) tick();

      // collision slot with toggling is_div, ALU request colliding with retire
      issue(5'd9, 1'b0); tick();
      issue(5'd10, 1'b1); tick();
      issue_valid = 1'b0; dec_reg_we = 1'b1; alu_wb_valid = 1'b1; alu_wb_rd = 5'd2;
      for (int i = 0; i < 10; i++) begin dec_is_div = ~dec_is_div; tick(); end
      idle_inputs();

      rand_cycles(400, 1'b0);

      // halt drain: divides at t=0 and t=3, halt_req at t=4
      do_reset();
      idle_inputs();
      issue(5'd4, 1'b0); tick();
      issue_valid = 1'b0; tick(); tick();
      issue(5'd6, 1'b1); tick();
      issue_valid = 1'b0; halt_req = 1'b1;
      for (int i = 0; i < 40 && !halt_ack; i++) tick();
      check("halt_ack_wait", 64'(halt_ack), 64'd1);
      halt_req = 1'b0;
      rand_cycles(30, 1'b1);

      // halt with an empty pipeline
      do_reset();
      idle_inputs(); tick();
      halt_req = 1'b1; tick(); tick(); tick();
      halt_req = 1'b0; tick();

      // reset mid-pipeline; nothing may retire afterwards
      rand_cycles(12, 1'b0);
      do_reset();
      idle_inputs();
      repeat (DEPTH + 4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
